// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds WIDTH-bit operands DIGIT bits per clock using a rippled 1-bit carry register.
// Optional subtract mode (sub port, a + ~b + 1) is enabled by defining DIGIT_SERIAL_ADDER_SUB_EN.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [WIDTH-1:0]   op_b;
  logic               op_cin;
  logic               last;
  logic [DIGIT-1:0]   a_dig, b_dig, sum_dig;
  logic [DIGIT:0]     dig_sum;
  logic               carry_next, msb_ovf;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  // Subtraction folds into the adder: invert b at capture and seed the carry with 1.
  assign op_b   = sub ? ~b : b;
  assign op_cin = sub ? 1'b1 : cin;
`else
  assign op_b   = b;
  assign op_cin = cin;
`endif

  assign last  = (cnt == CNT_W'(N - 1));
  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_dig      = a_reg[int'(cnt)*DIGIT +: DIGIT];
    b_dig      = b_reg[int'(cnt)*DIGIT +: DIGIT];
    dig_sum    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    sum_dig    = dig_sum[DIGIT-1:0];
    carry_next = dig_sum[DIGIT];
    // Carry into the MSB is recovered from the MSB sum bit, so DIGIT=1 needs no special case.
    msb_ovf    = carry_next ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum_dig[DIGIT-1];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_reg <= a;
      b_reg <= op_b;
      carry <= op_cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      s[int'(cnt)*DIGIT +: DIGIT] <= sum_dig;
      carry <= carry_next;
      // Counter parks on the last digit so the part-selects never leave the operand range.
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        cout <= carry_next;
        ovf  <= msb_ovf;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder: a 16/4 instance and an 8/8 instance.
// Subtract-mode vectors run only when DIGIT_SERIAL_ADDER_SUB_EN is defined.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        ready16, done16, cout16, ovf16;
  logic [15:0] s16;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  logic        sub16 = 1'b0;
`endif

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic        ready8, done8, cout8, ovf8;
  logic [7:0]  s8;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt16 = 0;
  int done_cnt8  = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .ready(ready16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .ready(ready8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  always @(posedge clk) begin
    if (done16) done_cnt16 <= done_cnt16 + 1;
    if (done8)  done_cnt8  <= done_cnt8 + 1;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic op16(input string tag, input logic [15:0] a_v, input logic [15:0] b_v,
                      input logic c_v, input logic sub_v, input logic spurious,
                      input logic [15:0] s_exp, input logic cout_exp, input logic ovf_exp);
    int cycles;
    int d0;
    logic cout_prev;
    check({tag, "_ready_pre"}, 32'(ready16), 32'd1);
    a16 = a_v; b16 = b_v; cin16 = c_v; start16 = 1'b1;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    sub16 = sub_v;
`endif
    d0 = done_cnt16;
    cout_prev = cout16;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    check({tag, "_ready_busy"}, 32'(ready16), 32'd0);
    cycles = 0;
    while (cycles < 20) begin
      if (spurious && cycles == 1) begin
        start16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1;
      end else begin
        start16 = 1'b0;
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (done16) break;
      if (cycles == 2) check({tag, "_cout_hold"}, 32'(cout16), 32'(cout_prev));
    end
    start16 = 1'b0;
    check({tag, "_latency"}, 32'(cycles), 32'd4);
    check({tag, "_s"},    32'(s16),    32'(s_exp));
    check({tag, "_cout"}, 32'(cout16), 32'(cout_exp));
    check({tag, "_ovf"},  32'(ovf16),  32'(ovf_exp));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'({done16, ready16}), 32'b01);
    check({tag, "_done_count"}, 32'(done_cnt16 - d0), 32'd1);
    check({tag, "_s_hold"}, 32'(s16), 32'(s_exp));
  endtask

  task automatic op8(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                     input logic c_v, input logic [7:0] s_exp, input logic cout_exp,
                     input logic ovf_exp);
    int cycles;
    a8 = a_v; b8 = b_v; cin8 = c_v; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    while (!done8 && cycles < 20) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(cycles), 32'd1);
    check({tag, "_s"},    32'(s8),    32'(s_exp));
    check({tag, "_cout"}, 32'(cout8), 32'(cout_exp));
    check({tag, "_ovf"},  32'(ovf8),  32'(ovf_exp));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, 32'({done8, ready8}), 32'b01);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    check("rst_state16", 32'({ready16, done16, cout16, ovf16}), 32'b1000);
    check("rst_s16", 32'(s16), 32'd0);
    check("rst_state8", 32'({ready8, done8, cout8, ovf8, s8}), 32'h800);
    rst = 1'b0;
    @(negedge clk);

    op16("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("posov", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("cin",   16'h1234, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h2346, 1'b0, 1'b0);
    op16("negov", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    op16("allone",16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    op16("spur",  16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1, 16'h0406, 1'b0, 1'b0);

    // Reset two digit edges into an operation.
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
    d0 = done_cnt16;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_flags", 32'({ready16, done16, cout16, ovf16}), 32'b1000);
    check("midrst_s", 32'(s16), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("midrst_no_done", 32'(done_cnt16 - d0), 32'd0);
    op16("after_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    op16("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    op16("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
    op16("add_back",16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h000D, 1'b0, 1'b0);
`endif

    op8("w8_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("w8_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("w8_cin", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits added per clock. WIDTH SHALL be an integer multiple of DIGIT, with 1 <= DIGIT <= WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: operation request.
REQ-006 SHALL have port a, input, WIDTH bits: operand A, captured when start is accepted.
REQ-007 SHALL have port b, input, WIDTH bits: operand B, captured when start is accepted.
REQ-008 SHALL have port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-009 SHALL have port ready, output, 1 bit: high when the block can accept start.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-011 SHALL have port s, output, WIDTH bits: registered sum.
REQ-012 SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement overflow.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE, with transitions:
- IDLE -> RUN when start=1.
- RUN -> DONE after N=WIDTH/DIGIT digit cycles.
- DONE -> IDLE unconditionally.
REQ-015 SHALL drive ready=1 only in IDLE; start SHALL be ignored in RUN and DONE, with no queuing and no effect on captured operands.
REQ-016 SHALL do the following on the accepting edge (edge 0): latch a, b and cin, and clear the digit counter.
REQ-017 SHALL add digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) on edge k+1, for k=0..N-1. The carry SHALL propagate between digits through a 1-bit carry register seeded with cin.
REQ-018 SHALL assert done=1 for exactly the one cycle following edge N (DONE state), and return ready=1 after edge N+1; latency from accept to done is N cycles.
REQ-019 SHALL make s, cout and ovf valid when done=1, and hold them unchanged until the next accepted start's final digit edge. Intermediate digits MAY update s, but cout and ovf SHALL change only on edge N.
REQ-020 SHALL set cout to the carry out of bit WIDTH-1, and ovf to carry-into-MSB XOR carry-out-of-MSB.
REQ-021 SHALL form results modulo 2^WIDTH; there is no saturation.
REQ-022 SHALL, when DIGIT=WIDTH, give N=1: done is asserted in the cycle after edge 1.
REQ-023 SHALL, when start=1 during DONE, ignore it; the earliest new accept is the cycle in which ready=1 again.

Reset
REQ-024 SHALL, while rst=1, force the following immediately, independent of clk:
- state to IDLE
- ready=1, done=0
- s=0, cout=0, ovf=0
- digit counter, carry register and operand registers to 0.
REQ-025 SHALL, on reset asserted mid-operation, abandon the operation with no done pulse; the first accept is possible on the first clk edge after rst deasserts.

Configuration
REQ-026 SHALL, when macro DIGIT_SERIAL_ADDER_SUB_EN is defined, add input port sub (1 bit), captured with the operands. With sub=1 the block SHALL compute a + ~b + 1 (cin ignored; carry register seeded with 1) and set cout=1 meaning no borrow; with sub=0 it SHALL behave as the plain adder.
REQ-027 SHALL, when DIGIT_SERIAL_ADDER_SUB_EN is undefined, have no sub port and always add using cin.

Verification
REQ-028 SHALL cover: WIDTH=16, DIGIT=4, a=0xFFFF, b=0x0001, cin=0 -> done 4 cycles after accept, s=0x0000, cout=1, ovf=0.
REQ-029 SHALL cover: a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; then a=0x1234, b=0x1111, cin=1 -> s=0x2346, cout=0, ovf=0.
REQ-030 SHALL cover: start pulsed during RUN with a=0xAAAA -> ignored; result reflects the first operands; done pulses once.
REQ-031 SHALL cover: rst asserted after 2 digit edges -> outputs immediately 0, ready=1, no done pulse; the next operation 0x0003+0x0004 -> s=0x0007.
REQ-032 SHALL cover, with DIGIT_SERIAL_ADDER_SUB_EN defined: sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0; then a=0x0007, b=0x0005 -> s=0x0002, cout=1.
REQ-033 SHALL cover: WIDTH=8, DIGIT=8, a=0x80, b=0x80 -> done 1 cycle after accept, s=0x00, cout=1, ovf=1.
